// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive side of the UART. It deserializes 8N1 frames arriving on uart_rx
// and buffers the received bytes in a small show-ahead FIFO. Sticky error
// flags report framing errors, overruns and, optionally, parity errors.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN):
//   defined   : an even-parity bit follows the data bits. On a mismatch
//               parity_err is set and the byte is dropped.
//   undefined : plain 8N1. There is no PARITY state, and parity_err is
//               tied to 0.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per bit period (>= 4, even)
//   FIFO_DEPTH   : FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst     : single clock; synchronous active-high reset
//   uart_rx      : serial input, idle high, asynchronous to clk
//   rx_data      : FIFO head byte (show-ahead)
//   rx_valid     : FIFO not empty
//   rx_ready     : consumer accepts the head byte
//   rx_count     : number of bytes held
//   frame_err    : sticky, stop bit sampled low
//   overrun      : sticky, byte arrived while the FIFO was full
//   parity_err   : sticky, parity mismatch (0 when parity is compiled out)
//   clear_err    : one-cycle pulse that clears every sticky flag
//   dbg_state_o  : current receiver FSM state
//
// Handshake: a byte transfers on every cycle in which rx_valid and rx_ready
// are both high. rx_data is stable while rx_valid=1 and rx_ready=0.
// rx_ready may be high while rx_valid=0; nothing happens in that case.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            uart_rx,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            frame_err,
  output logic                            overrun,
  output logic                            parity_err,
  input  logic                            clear_err,
  output logic [2:0]                      dbg_state_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // The baud counter is 0 on the first cycle of each state. These are the
  // counter values on the sample cycles: mid start bit, then one full bit
  // period for every later bit.
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // -------------------------------------------------------------------------
  // Input synchronizer. It resets to idle-high so reset does not look like a
  // start bit.
  // -------------------------------------------------------------------------
  logic sync1_q;
  logic rxs_q;
  logic rxs_prev_q;

  // -------------------------------------------------------------------------
  // Receiver FSM
  // -------------------------------------------------------------------------
  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q,  baud_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_push;
  logic          frame_evt;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          parity_evt;
`endif

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_push   = 1'b0;
    frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_evt = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        // Require a genuine 1->0 edge. A line left low (for example after a
        // framing error) does not retrigger the receiver.
        if (rxs_prev_q && !rxs_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_HALF) begin
          baud_d  = '0;
          bit_d   = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_FULL) begin
          baud_d  = '0;
          shift_d = {rxs_q, shift_q[7:1]};   // LSB arrives first
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_q == BAUD_FULL) begin
          baud_d    = '0;
          // Even parity: data ones plus the parity bit must be even.
          par_bad_d = rxs_q ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == BAUD_FULL) begin
          baud_d  = '0;
          // Return to IDLE immediately so that a start bit arriving from
          // mid stop bit onward is still caught.
          state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
          frame_evt  = !rxs_q;
          parity_evt = par_bad_q;
          rx_push    = rxs_q && !par_bad_q;
`else
          frame_evt  = !rxs_q;
          rx_push    = rxs_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          ovr_evt;

  assign full    = (count_q == DEPTH);
  assign pop     = rx_valid && rx_ready;
  // When the FIFO is full, a simultaneous pop frees the head slot. The
  // incoming byte then lands in that slot because wr_ptr == rd_ptr.
  assign do_push = rx_push && (!full || pop);
  assign ovr_evt = rx_push && full && !pop;

  logic frame_err_q;
  logic overrun_q;
`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q    <= uart_rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;

      if (do_push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (do_push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end

      // A new error event overrides a clear in the same cycle.
      frame_err_q <= (frame_err_q && !clear_err) || frame_evt;
      overrun_q   <= (overrun_q   && !clear_err) || ovr_evt;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= (parity_err_q && !clear_err) || parity_evt;
`endif
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_valid    = (count_q != '0);
  assign rx_count    = count_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=16 and FIFO_DEPTH=4.
// Inputs change on the falling clock edge. Outputs are sampled on the
// falling edge as well. Each frame task starts at a falling edge and
// returns on one.
//
// Timing reference: uart_rx is driven low at falling edge N0. The
// synchronized line is low from rising edge 2 onward, which makes that
// cycle t0. The push registers at the end of cycle t0+152, so rx_valid is
// first seen high at falling edge N155. A parity bit adds one more bit
// period.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int VALID_AT = 155 + CPB;
`else
  localparam int VALID_AT = 155;
`endif
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rx_ready;
  logic       clear_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic [2:0] dbg_state;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
`ifdef UART_RX_PARITY_EN
  logic       flip_parity = 1'b0;
`endif

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_count   (rx_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .clear_err  (clear_err),
    .dbg_state_o(dbg_state)
  );

  // -------------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic drive_frame(input logic [7:0] data, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^data) ^ flip_parity;
    repeat (CPB) @(negedge clk);
`endif
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    uart_rx   = 1'b1;
    rx_ready  = 1'b0;
    clear_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", rx_valid); end
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rx_count); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h want 00", rx_data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %0b want 0", parity_err); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_single_frame();
    fork
      drive_frame(8'hA5, 1'b1);
      begin
        repeat (VALID_AT - 1) @(negedge clk);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL a5_valid_early: got %0b want 0", rx_valid); end
        @(negedge clk);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL a5_valid_latency: got %0b want 1", rx_valid); end
      end
    join
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %02h want a5", rx_data); end
    n_checks++; if (rx_count !== 3'd1) begin n_fail++; $display("FAIL a5_count: got %0d want 1", rx_count); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL a5_frame_err: got %0b want 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL a5_overrun: got %0b want 0", overrun); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL a5_parity_err: got %0b want 0", parity_err); end
    pop_one();
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL a5_pop_valid: got %0b want 0", rx_valid); end
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL a5_pop_count: got %0d want 0", rx_count); end
  endtask

  task automatic test_false_start();
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (dbg_state !== ST_START) begin n_fail++; $display("FAIL glitch_in_start: got %0d want %0d", dbg_state, ST_START); end
    repeat (14) @(negedge clk);
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL glitch_back_idle: got %0d want %0d", dbg_state, ST_IDLE); end
    repeat (CPB * 10) @(negedge clk);
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", rx_count); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err: got %0b want 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL glitch_overrun: got %0b want 0", overrun); end
  endtask

  task automatic test_frame_error();
    drive_frame(8'h3C, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %0b want 1", frame_err); end
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL ferr_count: got %0d want 0", rx_count); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %0b want 0", rx_valid); end
    pulse_clear();
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %0b want 0", frame_err); end
    drive_frame(8'h3C, 1'b1);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_good_valid: got %0b want 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_good_data: got %02h want 3c", rx_data); end
    n_checks++; if (rx_count !== 3'd1) begin n_fail++; $display("FAIL ferr_good_count: got %0d want 1", rx_count); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_good_flag: got %0b want 0", frame_err); end
    pop_one();
    // clear_err lands on the same cycle as the bad stop sample: the set wins.
    fork
      drive_frame(8'h3C, 1'b0);
      begin
        repeat (VALID_AT - 1) @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set_wins: got %0b want 1", frame_err); end
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL ferr_set_wins_count: got %0d want 0", rx_count); end
    pulse_clear();
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear2: got %0b want 0", frame_err); end
  endtask

  task automatic test_overrun();
    exp_q.delete();
    for (int b = 1; b <= 5; b++) begin
      drive_frame(8'(b), 1'b1);
      if (b <= DEPTH) exp_q.push_back(8'(b));
    end
    n_checks++; if (rx_count !== 3'd4) begin n_fail++; $display("FAIL ovr_count: got %0d want 4", rx_count); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %0b want 1", overrun); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ovr_frame_err: got %0b want 0", frame_err); end
    // Hold rx_ready high: one byte should drain per cycle.
    rx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = exp_q.pop_front();
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_drain_valid[%0d]: got %0b want 1", i, rx_valid); end
      n_checks++; if (rx_data !== exp_b) begin n_fail++; $display("FAIL ovr_drain_data[%0d]: got %02h want %02h", i, rx_data, exp_b); end
      @(negedge clk);
    end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty_valid: got %0b want 0", rx_valid); end
    // rx_ready stays high for one more cycle on the empty FIFO.
    @(negedge clk);
    rx_ready = 1'b0;
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL ovr_pop_empty: got %0d want 0", rx_count); end
    pulse_clear();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %0b want 0", overrun); end
  endtask

  task automatic test_full_push_pop();
    exp_q.delete();
    for (int b = 1; b <= DEPTH; b++) begin
      drive_frame(8'(b), 1'b1);
    end
    for (int b = 2; b <= 5; b++) exp_q.push_back(8'(b));
    n_checks++; if (rx_count !== 3'd4) begin n_fail++; $display("FAIL fpp_fill: got %0d want 4", rx_count); end
    fork
      drive_frame(8'h05, 1'b1);
      begin
        repeat (VALID_AT - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fpp_overrun: got %0b want 0", overrun); end
        n_checks++; if (rx_count !== 3'd4) begin n_fail++; $display("FAIL fpp_count: got %0d want 4", rx_count); end
      end
    join
    rx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = exp_q.pop_front();
      n_checks++; if (rx_data !== exp_b) begin n_fail++; $display("FAIL fpp_data[%0d]: got %02h want %02h", i, rx_data, exp_b); end
      @(negedge clk);
    end
    rx_ready = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %0b want 0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    drive_frame(8'h99, 1'b1);
    n_checks++; if (rx_count !== 3'd1) begin n_fail++; $display("FAIL rmf_pre_count: got %0d want 1", rx_count); end
    // Reset is asserted mid bit 3 of 0x55 and released after the frame ends.
    fork
      drive_frame(8'h55, 1'b1);
      begin
        repeat (CPB * 4 + CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (CPB * 7) @(negedge clk);
        rst = 1'b0;
      end
    join
    @(negedge clk);
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL rmf_count: got %0d want 0", rx_count); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_valid: got %0b want 0", rx_valid); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rmf_state: got %0d want %0d", dbg_state, ST_IDLE); end
    drive_frame(8'h81, 1'b1);
    n_checks++; if (rx_count !== 3'd1) begin n_fail++; $display("FAIL rmf_81_count: got %0d want 1", rx_count); end
    n_checks++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL rmf_81_data: got %02h want 81", rx_data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rmf_frame_err: got %0b want 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rmf_overrun: got %0b want 0", overrun); end
    pop_one();
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL rmf_pop: got %0d want 0", rx_count); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    flip_parity = 1'b1;
    drive_frame(8'h81, 1'b1);
    flip_parity = 1'b0;
    n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_set: got %0b want 1", parity_err); end
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL par_count: got %0d want 0", rx_count); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL par_frame_err: got %0b want 0", frame_err); end
    pulse_clear();
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_clear: got %0b want 0", parity_err); end
    drive_frame(8'h81, 1'b1);
    n_checks++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL par_good_data: got %02h want 81", rx_data); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_good_flag: got %0b want 0", parity_err); end
    pop_one();
  endtask
`endif

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_frame();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_full_push_pop();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
